// File: rtl/knns_seq_td.sv
// knns_seq_td: streaming k-nearest-neighbour selector using L1 (taxicab) distance.
// A query point is latched on start. Database points then stream in at up to
// one per cycle through a two-stage pipeline: stage 1 registers the distance,
// and stage 2 shift-inserts the point into a sorted array of K slots.
//
// Handshake: e_valid qualifies e_input/e_last in RUN and is never back-pressured.
// start restarts from IDLE, RUN or DONE. busy covers RUN and the pipeline drain.
// o_valid is held high from DONE until the next start.
module knns_seq_td #(
  parameter int W  = 15,
  parameter int K  = 4,
  parameter int CW = $clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*W-1:0]        g_input,
  input  logic                  e_valid,
  input  logic [2*W-1:0]        e_input,
  input  logic                  e_last,
  output logic                  busy,
  output logic                  o_valid,
  output logic [2*W*K-1:0]      o,
  output logic [(W+2)*K-1:0]    o_dist,
  output logic [CW-1:0]         o_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   g_q, g_d;
  logic             s1_valid_q, s1_valid_d;
  logic [2*W-1:0]   s1_pt_q, s1_pt_d;
  logic [W+1:0]     s1_dist_q, s1_dist_d;
  logic [2*W-1:0]   pt_q [K];
  logic [2*W-1:0]   pt_d [K];
  logic [W+1:0]     dist_q [K];
  logic [W+1:0]     dist_d [K];
  logic             vld_q [K];
  logic             vld_d [K];
  logic [CW-1:0]    count_q, count_d;

  logic [W-1:0]     dx, dy;
  logic [W+1:0]     dist_new;
  logic [K-1:0]     beats;

  // Stage-1 distance: unsigned absolute differences summed without overflow.
  always_comb begin
    dx = (e_input[2*W-1:W] >= g_q[2*W-1:W]) ? (e_input[2*W-1:W] - g_q[2*W-1:W])
                                           : (g_q[2*W-1:W] - e_input[2*W-1:W]);
    dy = (e_input[W-1:0] >= g_q[W-1:0]) ? (e_input[W-1:0] - g_q[W-1:0])
                                       : (g_q[W-1:0] - e_input[W-1:0]);
    dist_new = {2'b00, dx} + {2'b00, dy};
  end

  // Per-slot comparators; strict less-than keeps earlier arrivals ahead on ties.
  // Because slots stay sorted with empty slots last, beats is a thermometer code.
  always_comb begin
    beats = '0;
    for (int j = 0; j < K; j++) begin
      beats[j] = s1_valid_q && (!vld_q[j] || (s1_dist_q < dist_q[j]));
    end
  end

  // Next-state: shift-insert, stage-1 capture and FSM; start overrides everything.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    s1_valid_d = 1'b0;
    s1_pt_d    = s1_pt_q;
    s1_dist_d  = s1_dist_q;
    count_d    = count_q;
    for (int j = 0; j < K; j++) begin
      pt_d[j]   = pt_q[j];
      dist_d[j] = dist_q[j];
      vld_d[j]  = vld_q[j];
    end

    // Stage 2: the lowest beaten slot takes the new point, the rest move down one.
    if (beats[0]) begin
      pt_d[0]   = s1_pt_q;
      dist_d[0] = s1_dist_q;
      vld_d[0]  = 1'b1;
    end
    for (int j = 1; j < K; j++) begin
      if (beats[j]) begin
        if (beats[j-1]) begin
          pt_d[j]   = pt_q[j-1];
          dist_d[j] = dist_q[j-1];
          vld_d[j]  = vld_q[j-1];
        end else begin
          pt_d[j]   = s1_pt_q;
          dist_d[j] = s1_dist_q;
          vld_d[j]  = 1'b1;
        end
      end
    end
    if ((|beats) && (count_q != CW'(K))) begin
      count_d = count_q + 1'b1;
    end

    case (state_q)
      RUN: begin
        if (!start && e_valid) begin
          s1_valid_d = 1'b1;
          s1_pt_d    = e_input;
          s1_dist_d  = dist_new;
          if (e_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last point commits while s1_valid_q is high; finish on the cycle after.
        if (!s1_valid_q) state_d = DONE;
      end
      default: ;
    endcase

    if (start && (state_q != DRAIN)) begin
      state_d    = RUN;
      g_d        = g_input;
      s1_valid_d = 1'b0;
      count_d    = '0;
      for (int j = 0; j < K; j++) begin
        pt_d[j]   = '0;
        dist_d[j] = '1;
        vld_d[j]  = 1'b0;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      g_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_pt_q    <= '0;
      s1_dist_q  <= '0;
      count_q    <= '0;
      for (int j = 0; j < K; j++) begin
        pt_q[j]   <= '0;
        dist_q[j] <= '1;
        vld_q[j]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      s1_valid_q <= s1_valid_d;
      s1_pt_q    <= s1_pt_d;
      s1_dist_q  <= s1_dist_d;
      count_q    <= count_d;
      for (int j = 0; j < K; j++) begin
        pt_q[j]   <= pt_d[j];
        dist_q[j] <= dist_d[j];
        vld_q[j]  <= vld_d[j];
      end
    end
  end

  // Outputs come straight from registers, so no path runs from e_input to any output.
  always_comb begin
    busy    = (state_q == RUN) || (state_q == DRAIN);
    o_valid = (state_q == DONE);
    o_count = count_q;
    o       = '0;
    o_dist  = '0;
    for (int j = 0; j < K; j++) begin
      o[2*W*j +: 2*W]        = pt_q[j];
      o_dist[(W+2)*j +: W+2] = dist_q[j];
    end
  end

endmodule

// File: tb/tb_knns_seq_td.sv
// tb_knns_seq_td: self-checking bench for knns_seq_td.
// The main instance uses W=8, K=3 and a second instance uses W=8, K=1.
// Expected results come from a stable sort of the stream by L1 distance.
module tb_knns_seq_td;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // K=3 instance
  logic        start, e_valid, e_last;
  logic [15:0] g_input, e_input;
  logic        busy, o_valid;
  logic [47:0] o;
  logic [29:0] o_dist;
  logic [1:0]  o_count;

  // K=1 instance
  logic        start1, ev1, el1;
  logic [15:0] g1, ei1;
  logic        busy1, ov1;
  logic [15:0] o1;
  logic [9:0]  od1;
  logic [0:0]  oc1;

  knns_seq_td #(.W(8), .K(3)) dut (
    .clk(clk), .rst(rst), .start(start), .g_input(g_input),
    .e_valid(e_valid), .e_input(e_input), .e_last(e_last),
    .busy(busy), .o_valid(o_valid), .o(o), .o_dist(o_dist), .o_count(o_count)
  );

  knns_seq_td #(.W(8), .K(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .g_input(g1),
    .e_valid(ev1), .e_input(ei1), .e_last(el1),
    .busy(busy1), .o_valid(ov1), .o(o1), .o_dist(od1), .o_count(oc1)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] stream_q[$];
  logic [15:0] cur_q;

  function automatic logic [15:0] pt(input int x, input int y);
    return {8'(x), 8'(y)};
  endfunction

  // Reference: stable sort of the stream by L1 distance, keep the first three.
  task automatic model_compute(input logic [15:0] gq, output logic [47:0] eo,
                               output logic [29:0] ed, output logic [1:0] ec);
    int d[$];
    bit used[$];
    int best;
    int ax, ay;
    eo = '0;
    ed = '1;
    ec = 2'd0;
    foreach (stream_q[i]) begin
      ax = int'(stream_q[i][15:8]) - int'(gq[15:8]);
      ay = int'(stream_q[i][7:0]) - int'(gq[7:0]);
      if (ax < 0) ax = -ax;
      if (ay < 0) ay = -ay;
      d.push_back(ax + ay);
      used.push_back(1'b0);
    end
    for (int s = 0; s < 3; s++) begin
      best = -1;
      for (int i = 0; i < d.size(); i++) begin
        if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        eo[16*s +: 16] = stream_q[best];
        ed[10*s +: 10] = 10'(d[best]);
        ec = ec + 2'd1;
      end
    end
  endtask

  task automatic do_start(input logic [15:0] g);
    start = 1'b1;
    g_input = g;
    cur_q = g;
    @(posedge clk); #1;
    start = 1'b0;
    g_input = 16'($urandom);
    stream_q.delete();
  endtask

  task automatic send_pt(input logic [15:0] p, input logic last);
    e_valid = 1'b1;
    e_input = p;
    e_last = last;
    @(posedge clk); #1;
    e_valid = 1'b0;
    e_last = 1'b0;
    e_input = 16'($urandom);
    stream_q.push_back(p);
  endtask

  task automatic idle_cycle();
    e_input = 16'($urandom);
    e_last = 1'($urandom);
    @(posedge clk); #1;
    e_last = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    while (o_valid !== 1'b1 && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    vectors++;
    if (o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: o_valid=%b expected 1 within 10 cycles", name, o_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    vectors += 5;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (o !== 48'h0) begin miscompares++; $display("FAIL reset_o: got %h expected 0", o); end
    if (o_count !== 2'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    if (o_dist !== 30'h3FFFFFFF) begin miscompares++; $display("FAIL reset_dist: got %h expected 3fffffff", o_dist); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [47:0] eo;
    logic [29:0] ed;
    logic [1:0]  ec;
    do_start(pt(10, 10));
    send_pt(pt(10, 12), 1'b0);
    send_pt(pt(0, 0), 1'b0);
    send_pt(pt(11, 10), 1'b0);
    send_pt(pt(10, 9), 1'b0);
    send_pt(pt(30, 30), 1'b1);
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL basic_lat1: o_valid=%b expected 0", o_valid); end
    @(posedge clk); #1;
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL basic_lat2: o_valid=%b expected 0", o_valid); end
    @(posedge clk); #1;
    vectors++;
    if (o_valid !== 1'b1) begin miscompares++; $display("FAIL basic_lat3: o_valid=%b expected 1", o_valid); end
    model_compute(cur_q, eo, ed, ec);
    vectors += 5;
    if (o !== {pt(10, 12), pt(10, 9), pt(11, 10)}) begin miscompares++; $display("FAIL basic_o_fixed: got %h", o); end
    if (o_dist !== {10'd2, 10'd1, 10'd1}) begin miscompares++; $display("FAIL basic_dist_fixed: got %h", o_dist); end
    if (o !== eo) begin miscompares++; $display("FAIL basic_o: got %h expected %h", o, eo); end
    if (o_dist !== ed) begin miscompares++; $display("FAIL basic_dist: got %h expected %h", o_dist, ed); end
    if (o_count !== ec) begin miscompares++; $display("FAIL basic_count: got %0d expected %0d", o_count, ec); end
  endtask

  task automatic test_underfill();
    logic [47:0] eo;
    logic [29:0] ed;
    logic [1:0]  ec;
    do_start(pt(5, 5));
    send_pt(pt(6, 6), 1'b0);
    send_pt(pt(5, 5), 1'b1);
    wait_valid("underfill");
    model_compute(cur_q, eo, ed, ec);
    vectors += 4;
    if (o_dist !== {10'h3FF, 10'd2, 10'd0}) begin miscompares++; $display("FAIL underfill_dist_fixed: got %h", o_dist); end
    if (o !== eo) begin miscompares++; $display("FAIL underfill_o: got %h expected %h", o, eo); end
    if (o_dist !== ed) begin miscompares++; $display("FAIL underfill_dist: got %h expected %h", o_dist, ed); end
    if (o_count !== ec) begin miscompares++; $display("FAIL underfill_count: got %0d expected %0d", o_count, ec); end
  endtask

  task automatic test_gapped();
    logic [15:0] pts[5];
    logic [47:0] eo;
    logic [29:0] ed;
    logic [1:0]  ec;
    int c;
    pts[0] = pt(10, 12); pts[1] = pt(0, 0); pts[2] = pt(11, 10);
    pts[3] = pt(10, 9);  pts[4] = pt(30, 30);
    do_start(pt(10, 10));
    for (int i = 0; i < 5; i++) begin
      send_pt(pts[i], 1'(i == 4));
      if (i < 4) begin
        repeat ($urandom_range(1, 3)) begin
          idle_cycle();
          vectors++;
          if (busy !== 1'b1) begin miscompares++; $display("FAIL gapped_busy_gap: got %b expected 1", busy); end
        end
      end
    end
    c = 0;
    while (o_valid !== 1'b1 && c < 10) begin
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL gapped_busy_drain: got %b expected 1", busy); end
      @(posedge clk); #1;
      c++;
    end
    model_compute(cur_q, eo, ed, ec);
    vectors += 5;
    if (o_valid !== 1'b1) begin miscompares++; $display("FAIL gapped_timeout: o_valid=%b expected 1", o_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL gapped_busy_done: got %b expected 0", busy); end
    if (o !== eo) begin miscompares++; $display("FAIL gapped_o: got %h expected %h", o, eo); end
    if (o_dist !== ed) begin miscompares++; $display("FAIL gapped_dist: got %h expected %h", o_dist, ed); end
    if (o_count !== ec) begin miscompares++; $display("FAIL gapped_count: got %0d expected %0d", o_count, ec); end
  endtask

  task automatic test_restart();
    logic [47:0] eo;
    logic [29:0] ed;
    logic [1:0]  ec;
    do_start(pt(10, 10));
    send_pt(pt(3, 4), 1'b0);
    send_pt(pt(9, 9), 1'b0);
    do_start(pt(0, 0));
    send_pt(pt(1, 0), 1'b1);
    wait_valid("restart");
    model_compute(cur_q, eo, ed, ec);
    vectors += 4;
    if (o !== {32'h0, pt(1, 0)}) begin miscompares++; $display("FAIL restart_o_fixed: got %h", o); end
    if (o !== eo) begin miscompares++; $display("FAIL restart_o: got %h expected %h", o, eo); end
    if (o_dist !== ed) begin miscompares++; $display("FAIL restart_dist: got %h expected %h", o_dist, ed); end
    if (o_count !== ec) begin miscompares++; $display("FAIL restart_count: got %0d expected %0d", o_count, ec); end
  endtask

  task automatic test_reset_midrun();
    logic [47:0] eo;
    logic [29:0] ed;
    logic [1:0]  ec;
    do_start(pt(10, 10));
    send_pt(pt(10, 11), 1'b0);
    send_pt(pt(12, 10), 1'b0);
    idle_cycle();
    vectors += 2;
    if (o_count !== 2'd2) begin miscompares++; $display("FAIL midrun_count_pre: got %0d expected 2", o_count); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL midrun_busy_pre: got %b expected 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    vectors += 5;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL midrun_o_valid: got %b expected 0", o_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrun_busy: got %b expected 0", busy); end
    if (o !== 48'h0) begin miscompares++; $display("FAIL midrun_o: got %h expected 0", o); end
    if (o_count !== 2'd0) begin miscompares++; $display("FAIL midrun_count: got %0d expected 0", o_count); end
    if (o_dist !== 30'h3FFFFFFF) begin miscompares++; $display("FAIL midrun_dist: got %h expected 3fffffff", o_dist); end
    @(negedge clk);
    rst = 1'b0;
    do_start(pt(10, 10));
    send_pt(pt(10, 12), 1'b0);
    send_pt(pt(30, 30), 1'b1);
    wait_valid("after_reset");
    model_compute(cur_q, eo, ed, ec);
    vectors += 3;
    if (o !== eo) begin miscompares++; $display("FAIL after_reset_o: got %h expected %h", o, eo); end
    if (o_dist !== ed) begin miscompares++; $display("FAIL after_reset_dist: got %h expected %h", o_dist, ed); end
    if (o_count !== ec) begin miscompares++; $display("FAIL after_reset_count: got %0d expected %0d", o_count, ec); end
  endtask

  task automatic test_width_extreme();
    int c;
    start1 = 1'b1;
    g1 = 16'h0000;
    @(posedge clk); #1;
    start1 = 1'b0;
    ev1 = 1'b1; ei1 = pt(255, 255); el1 = 1'b0;
    @(posedge clk); #1;
    ev1 = 1'b0;
    @(posedge clk); #1;
    vectors += 3;
    if (od1 !== 10'd510) begin miscompares++; $display("FAIL extreme_dist510: got %0d expected 510", od1); end
    if (o1 !== 16'hFFFF) begin miscompares++; $display("FAIL extreme_o_first: got %h expected ffff", o1); end
    if (oc1 !== 1'b1) begin miscompares++; $display("FAIL extreme_count_first: got %0d expected 1", oc1); end
    ev1 = 1'b1; ei1 = pt(255, 254); el1 = 1'b1;
    @(posedge clk); #1;
    ev1 = 1'b0; el1 = 1'b0;
    c = 0;
    while (ov1 !== 1'b1 && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    vectors += 4;
    if (ov1 !== 1'b1) begin miscompares++; $display("FAIL extreme_timeout: o_valid=%b expected 1", ov1); end
    if (o1 !== 16'hFFFE) begin miscompares++; $display("FAIL extreme_o: got %h expected fffe", o1); end
    if (od1 !== 10'd509) begin miscompares++; $display("FAIL extreme_dist: got %0d expected 509", od1); end
    if (oc1 !== 1'b1) begin miscompares++; $display("FAIL extreme_count: got %0d expected 1", oc1); end
  endtask

  task automatic test_random();
    logic [47:0] eo;
    logic [29:0] ed;
    logic [1:0]  ec;
    logic [15:0] p;
    int n;
    for (int r = 0; r < 16; r++) begin
      do_start(16'($urandom));
      if (r % 2 == 0) begin
        do_start(pt($urandom_range(0, 15), $urandom_range(0, 15)));
      end
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        if (r % 2 == 0) p = pt($urandom_range(0, 15), $urandom_range(0, 15));
        else p = 16'($urandom);
        send_pt(p, 1'(i == n - 1));
        if (i < n - 1) repeat ($urandom_range(0, 2)) idle_cycle();
      end
      wait_valid("random");
      model_compute(cur_q, eo, ed, ec);
      vectors += 3;
      if (o !== eo) begin miscompares++; $display("FAIL random_o run %0d: got %h expected %h", r, o, eo); end
      if (o_dist !== ed) begin miscompares++; $display("FAIL random_dist run %0d: got %h expected %h", r, o_dist, ed); end
      if (o_count !== ec) begin miscompares++; $display("FAIL random_count run %0d: got %0d expected %0d", r, o_count, ec); end
    end
  endtask

  initial begin
    start = 1'b0; g_input = '0; e_valid = 1'b0; e_input = '0; e_last = 1'b0;
    start1 = 1'b0; g1 = '0; ev1 = 1'b0; ei1 = '0; el1 = 1'b0;
    test_reset();
    test_basic();
    test_underfill();
    test_gapped();
    test_restart();
    test_reset_midrun();
    test_width_extreme();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
